// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer fed by the rename stage.
// Entries are allocated at the tail, marked done by execution units via tag,
// and retired one per cycle from the head. The retire_* outputs are
// registered and hand the displaced physical register back to the free list.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int PREG_W = 6,
  parameter int AREG_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,

  input  logic              alloc_valid,
  input  logic [AREG_W-1:0] alloc_arch_rd,
  input  logic [PREG_W-1:0] alloc_phys_rd,
  input  logic [PREG_W-1:0] alloc_old_phys_rd,
  input  logic              alloc_reg_write,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,

  input  logic              complete_valid,
  input  logic [TAG_W-1:0]  complete_tag,

  output logic              retire_valid,
  output logic              retire_reg_write,
  output logic [AREG_W-1:0] retire_arch_rd,
  output logic [PREG_W-1:0] retire_phys_rd,
  output logic [PREG_W-1:0] retire_phys_reg,

  output logic              full,
  output logic              empty,
  output logic [TAG_W:0]    count
);

  localparam logic [TAG_W:0]   COUNT_FULL = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] PTR_ONE    = TAG_W'(1);

  // Per-entry control state (reset) and payload (not reset).
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [DEPTH-1:0]  reg_write_q, reg_write_d;
  logic [AREG_W-1:0] arch_rd_q     [DEPTH];
  logic [AREG_W-1:0] arch_rd_d     [DEPTH];
  logic [PREG_W-1:0] phys_rd_q     [DEPTH];
  logic [PREG_W-1:0] phys_rd_d     [DEPTH];
  logic [PREG_W-1:0] old_phys_rd_q [DEPTH];
  logic [PREG_W-1:0] old_phys_rd_d [DEPTH];

  // Pointers and occupancy.
  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;

  // Registered retire port.
  logic              ret_valid_q, ret_valid_d;
  logic              ret_reg_write_q, ret_reg_write_d;
  logic [AREG_W-1:0] ret_arch_rd_q, ret_arch_rd_d;
  logic [PREG_W-1:0] ret_phys_rd_q, ret_phys_rd_d;
  logic [PREG_W-1:0] ret_old_phys_q, ret_old_phys_d;

  logic              full_w;
  logic              alloc_fire;
  logic              retire_fire;
  logic              complete_hit;

  // Status flags derive from count so head == tail is never ambiguous.
  always_comb begin
    full_w       = (count_q == COUNT_FULL);
    alloc_fire   = alloc_valid && !full_w;
    retire_fire  = valid_q[head_q] && done_q[head_q];
    complete_hit = complete_valid && valid_q[complete_tag];
  end

  assign full         = full_w;
  assign empty        = (count_q == '0);
  assign count        = count_q;
  assign alloc_ready  = !full_w;
  assign alloc_tag    = tail_q;

  assign retire_valid     = ret_valid_q;
  assign retire_reg_write = ret_reg_write_q;
  assign retire_arch_rd   = ret_arch_rd_q;
  assign retire_phys_rd   = ret_phys_rd_q;
  assign retire_phys_reg  = ret_old_phys_q;

  // Control next-state: flush wins over alloc, complete and retire.
  always_comb begin
    valid_d         = valid_q;
    done_d          = done_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    ret_valid_d     = 1'b0;
    ret_reg_write_d = ret_reg_write_q;
    ret_arch_rd_d   = ret_arch_rd_q;
    ret_phys_rd_d   = ret_phys_rd_q;
    ret_old_phys_d  = ret_old_phys_q;

    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Retire decision uses the pre-edge done bit, so a completion of the
      // head only becomes visible at retire one edge later.
      if (complete_hit) begin
        done_d[complete_tag] = 1'b1;
      end
      if (retire_fire) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_q + PTR_ONE;
        ret_valid_d     = 1'b1;
        ret_reg_write_d = reg_write_q[head_q];
        ret_arch_rd_d   = arch_rd_q[head_q];
        ret_phys_rd_d   = phys_rd_q[head_q];
        ret_old_phys_d  = old_phys_rd_q[head_q];
      end
      // The tail slot is always invalid when allocation fires, so it never
      // collides with the head being retired or with a completion.
      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        tail_d          = tail_q + PTR_ONE;
      end
      count_d = count_q + {{TAG_W{1'b0}}, alloc_fire}
                        - {{TAG_W{1'b0}}, retire_fire};
    end
  end

  // Payload next-state: written only at the tail on an accepted allocation.
  always_comb begin
    reg_write_d   = reg_write_q;
    arch_rd_d     = arch_rd_q;
    phys_rd_d     = phys_rd_q;
    old_phys_rd_d = old_phys_rd_q;
    if (alloc_fire && !flush) begin
      reg_write_d[tail_q]   = alloc_reg_write;
      arch_rd_d[tail_q]     = alloc_arch_rd;
      phys_rd_d[tail_q]     = alloc_phys_rd;
      old_phys_rd_d[tail_q] = alloc_old_phys_rd;
    end
  end

  // Control and retire-port registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q         <= '0;
      done_q          <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      ret_valid_q     <= 1'b0;
      ret_reg_write_q <= 1'b0;
      ret_arch_rd_q   <= '0;
      ret_phys_rd_q   <= '0;
      ret_old_phys_q  <= '0;
    end else begin
      valid_q         <= valid_d;
      done_q          <= done_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      ret_valid_q     <= ret_valid_d;
      ret_reg_write_q <= ret_reg_write_d;
      ret_arch_rd_q   <= ret_arch_rd_d;
      ret_phys_rd_q   <= ret_phys_rd_d;
      ret_old_phys_q  <= ret_old_phys_d;
    end
  end

  // Entry payload storage; qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    reg_write_q   <= reg_write_d;
    arch_rd_q     <= arch_rd_d;
    phys_rd_q     <= phys_rd_d;
    old_phys_rd_q <= old_phys_rd_d;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed and randomized stimulus against a queue-based
// program-order model; retirements are checked by a separate monitor.
module tb_reorder_buffer;

  localparam int DEPTH  = 16;
  localparam int TAG_W  = 4;
  localparam int PREG_W = 6;
  localparam int AREG_W = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              flush;
  logic              alloc_valid;
  logic [AREG_W-1:0] alloc_arch_rd;
  logic [PREG_W-1:0] alloc_phys_rd;
  logic [PREG_W-1:0] alloc_old_phys_rd;
  logic              alloc_reg_write;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              complete_valid;
  logic [TAG_W-1:0]  complete_tag;
  logic              retire_valid;
  logic              retire_reg_write;
  logic [AREG_W-1:0] retire_arch_rd;
  logic [PREG_W-1:0] retire_phys_rd;
  logic [PREG_W-1:0] retire_phys_reg;
  logic              full;
  logic              empty;
  logic [TAG_W:0]    count;

  reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PREG_W(PREG_W), .AREG_W(AREG_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_arch_rd(alloc_arch_rd),
    .alloc_phys_rd(alloc_phys_rd), .alloc_old_phys_rd(alloc_old_phys_rd),
    .alloc_reg_write(alloc_reg_write), .alloc_ready(alloc_ready),
    .alloc_tag(alloc_tag), .complete_valid(complete_valid),
    .complete_tag(complete_tag), .retire_valid(retire_valid),
    .retire_reg_write(retire_reg_write), .retire_arch_rd(retire_arch_rd),
    .retire_phys_rd(retire_phys_rd), .retire_phys_reg(retire_phys_reg),
    .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [AREG_W-1:0] arch;
    logic [PREG_W-1:0] phys;
    logic [PREG_W-1:0] old;
    logic              rw;
    bit                done;
  } ent_t;

  ent_t             rob[$];     // live entries, oldest first
  ent_t             exp_q[$];   // predicted retirements awaiting the monitor
  logic [TAG_W-1:0] m_tail;
  int               errors = 0;
  int               checks = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0; alloc_valid = 1'b0; complete_valid = 1'b0;
    alloc_arch_rd = '0; alloc_phys_rd = '0; alloc_old_phys_rd = '0;
    alloc_reg_write = 1'b0; complete_tag = '0;
  endtask

  task automatic set_alloc(int arch, int phys, int old, bit rw);
    alloc_valid       = 1'b1;
    alloc_arch_rd     = AREG_W'(arch);
    alloc_phys_rd     = PREG_W'(phys);
    alloc_old_phys_rd = PREG_W'(old);
    alloc_reg_write   = rw;
  endtask

  // Advance the model by one edge from the current inputs, clock the DUT,
  // compare status after the edge, and return at the next falling edge.
  task automatic tick();
    bit   m_ret;
    bit   m_alloc;
    ent_t e;
    m_ret = 1'b0;
    if (flush) begin
      rob.delete();
      m_tail = '0;
    end else begin
      m_ret   = (rob.size() > 0) && rob[0].done;
      m_alloc = alloc_valid && (rob.size() < DEPTH);
      if (complete_valid)
        foreach (rob[i]) if (rob[i].tag == complete_tag) rob[i].done = 1'b1;
      if (m_ret) begin
        exp_q.push_back(rob[0]);
        void'(rob.pop_front());
      end
      if (m_alloc) begin
        e.tag = m_tail; e.arch = alloc_arch_rd; e.phys = alloc_phys_rd;
        e.old = alloc_old_phys_rd; e.rw = alloc_reg_write; e.done = 1'b0;
        rob.push_back(e);
        m_tail = m_tail + 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("count", count, rob.size());
    check("full", full, rob.size() == DEPTH);
    check("empty", empty, rob.size() == 0);
    check("alloc_ready", alloc_ready, rob.size() < DEPTH);
    check("alloc_tag", alloc_tag, m_tail);
    check("retire_valid", retire_valid, m_ret);
    @(negedge clk);
  endtask

  // Monitor: every retirement pulse must match the oldest predicted entry.
  always @(negedge clk) begin
    if (reset_n && retire_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_retire: got retire_valid=1 required no retire at %0t", $time);
      end else begin
        ent_t x;
        x = exp_q.pop_front();
        check("retire_reg_write", retire_reg_write, x.rw);
        check("retire_arch_rd", retire_arch_rd, x.arch);
        check("retire_phys_rd", retire_phys_rd, x.phys);
        check("retire_phys_reg", retire_phys_reg, x.old);
      end
    end
  end

  int t0;
  int ctag;

  initial begin
    idle_inputs();
    m_tail  = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_alloc_tag", alloc_tag, 0);
    check("rst_retire_valid", retire_valid, 0);
    check("rst_retire_phys_reg", retire_phys_reg, 0);
    @(negedge clk);

    // Three entries completed in reverse order retire in program order.
    for (int i = 0; i < 3; i++) begin
      set_alloc(i + 1, 33 + i, i + 1, 1'b1);
      tick();
    end
    alloc_valid = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      complete_valid = 1'b1; complete_tag = TAG_W'(i);
      tick();
    end
    complete_valid = 1'b0;
    repeat (4) tick();
    check("t1_empty", empty, 1);

    // Fill from tag 0, refuse overflow, then retire-while-full boundary.
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_alloc(i, 40 + i, i, (i % 3) != 0);
      tick();
    end
    check("fill_full", full, 1);
    check("fill_ready", alloc_ready, 0);
    check("fill_count", count, 16);
    set_alloc(31, 63, 30, 1'b1);
    tick();
    check("overflow_tag", alloc_tag, 0);
    alloc_valid = 1'b0;
    complete_valid = 1'b1; complete_tag = '0;
    tick();
    complete_valid = 1'b0;
    set_alloc(7, 20, 21, 1'b1);
    tick();
    check("full_retire_count", count, 15);
    tick();
    check("refill_count", count, 16);
    alloc_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      complete_valid = 1'b1; complete_tag = TAG_W'(i);
      tick();
    end
    complete_valid = 1'b0;
    repeat (20) tick();
    check("drain_empty", empty, 1);

    // Completion latency, invalid-tag completion, reg_write=0 entry.
    t0 = int'(m_tail);
    set_alloc(9, 10, 11, 1'b0);
    tick();
    alloc_valid = 1'b0;
    complete_valid = 1'b1; complete_tag = TAG_W'(t0 + 3);
    tick();
    complete_tag = TAG_W'(t0);
    tick();
    complete_valid = 1'b0;
    repeat (3) tick();

    // Flush with live and partially done entries drops a simultaneous alloc.
    t0 = int'(m_tail);
    for (int i = 0; i < 5; i++) begin
      set_alloc(i + 10, i + 50, i + 20, 1'b1);
      tick();
    end
    alloc_valid = 1'b0;
    complete_valid = 1'b1; complete_tag = TAG_W'(t0 + 1); tick();
    complete_tag = TAG_W'(t0 + 2); tick();
    complete_valid = 1'b0;
    flush = 1'b1;
    set_alloc(1, 2, 3, 1'b1);
    tick();
    flush = 1'b0; alloc_valid = 1'b0;
    check("flush_count", count, 0);
    check("flush_tag", alloc_tag, 0);
    check("flush_retire", retire_valid, 0);
    tick();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) < 6)
        set_alloc($urandom_range(0, 31), $urandom_range(0, 63),
                  $urandom_range(0, 63), $urandom_range(0, 1) == 1);
      else
        alloc_valid = 1'b0;
      complete_valid = ($urandom_range(0, 9) < 7);
      if (rob.size() > 0 && $urandom_range(0, 9) < 8)
        ctag = int'(rob[$urandom_range(0, rob.size() - 1)].tag);
      else
        ctag = $urandom_range(0, DEPTH - 1);
      complete_tag = TAG_W'(ctag);
      tick();
    end
    idle_inputs();

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 4; i++) begin
      set_alloc(i + 3, i + 12, i + 5, 1'b1);
      tick();
    end
    alloc_valid = 1'b0;
    complete_valid = 1'b1; complete_tag = rob[0].tag;
    tick();
    complete_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_retire_valid", retire_valid, 0);
    check("arst_retire_phys_reg", retire_phys_reg, 0);
    check("arst_alloc_tag", alloc_tag, 0);
    rob.delete();
    m_tail = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_alloc(i + 1, i + 60, i + 8, i != 1);
      tick();
    end
    alloc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      complete_valid = 1'b1; complete_tag = TAG_W'(i);
      tick();
    end
    complete_valid = 1'b0;
    repeat (5) tick();

    // Drain anything left and confirm every predicted retirement was seen.
    while (rob.size() > 0) begin
      complete_valid = 1'b1; complete_tag = rob[0].tag;
      tick();
    end
    complete_valid = 1'b0;
    repeat (4) tick();
    check("pending_retires", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
In-order retirement buffer sitting directly downstream of the rename stage. Every renamed instruction gets an entry at dispatch. Execution units mark entries complete by tag. Entries retire strictly in program order; each retirement returns the displaced physical register to the rename free list through rename's retire_valid/retire_phys_reg inputs.

Parameters:
DEPTH, 16, number of entries; power of two, at least 4
TAG_W, 4, entry tag width; equals log2(DEPTH)
PREG_W, 6, physical register index width
AREG_W, 5, architectural register index width

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all entries
alloc_valid  input  1  dispatch request from rename
alloc_arch_rd  input  AREG_W  architectural destination
alloc_phys_rd  input  PREG_W  newly mapped physical destination
alloc_old_phys_rd  input  PREG_W  previous mapping of arch_rd, freed at retire
alloc_reg_write  input  1  instruction writes a register
alloc_ready  output  1  !full; combinational
alloc_tag  output  TAG_W  tail index = tag given to this cycle's allocation; combinational
complete_valid  input  1  execution writeback strobe
complete_tag  input  TAG_W  entry being completed
retire_valid  output  1  registered one-cycle pulse, one entry retired
retire_reg_write  output  1  registered; retired entry wrote a register
retire_arch_rd  output  AREG_W  registered arch rd of retired entry
retire_phys_rd  output  PREG_W  registered new phys rd (commit map update)
retire_phys_reg  output  PREG_W  registered old phys rd, to be freed
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  TAG_W+1  occupied entries

Behaviour:
- Storage: per entry valid, done, arch_rd, phys_rd, old_phys_rd, reg_write. Pointers head and tail are TAG_W bits and wrap naturally modulo DEPTH. count is TAG_W+1 bits.
- Reset (async, reset_n=0): all valid/done=0, head=tail=0, count=0, retire_valid=0. All retire_* data outputs=0.
- Allocate: at the edge with alloc_valid && !full, write the fields at tail, set valid=1 and done=0, then tail+1. alloc_valid while full is ignored with no state change; the upstream pipeline stalls on !alloc_ready.
- Complete: at the edge with complete_valid && valid[complete_tag], set done=1. A completion to an invalid entry or an already-done entry is a silent no-op.
- Retire: at most one per cycle. At the edge where valid[head] && done[head]:
  - Load the retire_* registers from the head entry and set retire_valid=1.
  - Clear valid[head] and advance head+1.
  - Otherwise retire_valid=0 on that edge.
- Latency:
  - Completion of the head entry at edge N gives retire_valid=1 after edge N+1. There is no same-cycle bypass of done into retire.
  - An allocation at edge N can retire no earlier than after edge N+2.
- Simultaneous events:
  - Alloc and retire in the same cycle: both occur and count is unchanged.
  - When full, alloc is refused even if a retire occurs on the same edge (full is evaluated pre-edge).
  - Complete and alloc to the same index cannot coincide, since the tail slot is invalid.
- count next = count + alloc_fire − retire_fire. full and empty derive from count, so they are unambiguous when head == tail.
- Flush (synchronous, highest priority): on that edge clear all valid/done, set head=tail=0 and count=0, and force retire_valid=0. Any simultaneous alloc, complete or retire is discarded.
- Reset asserted mid-operation discards all contents immediately, regardless of clk.

Test Plan:
- Reset, then idle: empty=1, full=0, count=0, alloc_tag=0, retire_valid=0.
- Alloc 3 entries (arch 1/2/3, phys 33/34/35, old 1/2/3); complete tags 2, 1, 0 on consecutive cycles -> no retire until tag 0 is done. Then retire_valid pulses on 3 consecutive cycles with retire_phys_reg = 1, 2, 3 in order; empty=1 afterward.
- Alloc 16 entries -> full=1, alloc_ready=0, count=16. A 17th alloc_valid is ignored (tail stays 0). Complete and retire one entry -> alloc_ready=1 and the next alloc gets tag 0 (wrap).
- With the ROB full and head done, assert alloc_valid on the retire edge -> retire occurs, alloc refused, count=15. Next cycle the alloc is accepted and count=16.
- Complete head at edge N -> retire_valid=1 exactly after N+1. Complete an invalid tag -> no state change. An entry with reg_write=0 retires with retire_reg_write=0.
- 5 entries live with 2 done; assert flush together with alloc_valid -> count=0, head=tail=0, retire_valid=0 next cycle, and the new alloc is dropped. Assert reset_n low mid-stream -> outputs clear asynchronously.
